// File: rtl/rng_seq_pkg.sv
// rng_seq_pkg: shared types and defaults for the RNG test sequencer.
// Optional feature macro: RNG_SEQ_FAIL_ALARM_EN (see rng_test_sequencer).
package rng_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FEED,
    WAIT,
    NEXT,
    DONE
  } state_t;

  localparam int DEF_SEQ_LEN     = 128;
  localparam int DEF_NUM_TESTS   = 16;
  localparam int DEF_TIMEOUT     = 1024;
  localparam int DEF_FAIL_THRESH = 3;

  // Width of a counter that must hold 0..n inclusive.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Width of a counter that runs 0..n-1.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rng_seq_if.sv
// rng_seq_if: run control, entropy, epsilon and verdict signals.
// slave = sequencer side, master = environment side.
interface rng_seq_if #(
  parameter int CW = 5
) ();

  logic          start;
  logic          rng_bit;
  logic          rng_bit_vld;
  logic          eps_bit;
  logic          eps_vld;
  logic          core_valid;
  logic          core_is_random;
  logic          busy;
  logic          done;
  logic [CW-1:0] pass_cnt;
  logic [CW-1:0] test_cnt;
  logic          timeout_err;
`ifdef RNG_SEQ_FAIL_ALARM_EN
  logic          alarm;
`endif

  modport slave (
    input  start,
    input  rng_bit,
    input  rng_bit_vld,
    input  core_valid,
    input  core_is_random,
    output eps_bit,
    output eps_vld,
    output busy,
    output done,
    output pass_cnt,
    output test_cnt,
`ifdef RNG_SEQ_FAIL_ALARM_EN
    output alarm,
`endif
    output timeout_err
  );

  modport master (
    output start,
    output rng_bit,
    output rng_bit_vld,
    output core_valid,
    output core_is_random,
    input  eps_bit,
    input  eps_vld,
    input  busy,
    input  done,
    input  pass_cnt,
    input  test_cnt,
`ifdef RNG_SEQ_FAIL_ALARM_EN
    input  alarm,
`endif
    input  timeout_err
  );

endinterface

// File: rtl/rng_bit_feeder.sv
// rng_bit_feeder: gated 1-cycle register from rng_bit to eps_bit, plus
// SEQ_LEN bit counter. Ports: clk, rst, clr, en, rng_bit(_vld) in;
// eps_bit, eps_vld, last_bit (comb, on the accepted final bit) out.
module rng_bit_feeder
  import rng_seq_pkg::*;
#(
  parameter int SEQ_LEN = DEF_SEQ_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic rng_bit,
  input  logic rng_bit_vld,
  output logic eps_bit,
  output logic eps_vld,
  output logic last_bit
);

  localparam int BW = idx_w(SEQ_LEN);
  localparam logic [BW-1:0] LAST = BW'(SEQ_LEN - 1);

  logic [BW-1:0] bit_cnt;
  logic          take;

  assign take     = en & rng_bit_vld;
  assign last_bit = take & (bit_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eps_bit <= 1'b0;
      eps_vld <= 1'b0;
      bit_cnt <= '0;
    end else begin
      eps_vld <= take;
      if (take)
        eps_bit <= rng_bit;
      if (clr || last_bit)
        bit_cnt <= '0;
      else if (take)
        bit_cnt <= bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rng_test_sequencer.sv
// rng_test_sequencer: feeds NUM_TESTS epsilon sequences of SEQ_LEN bits to
// the approximate-entropy core and tallies verdicts/timeouts.
// Ports: clk, rst (async, high), bus (rng_seq_if.slave).
// Optional: `define RNG_SEQ_FAIL_ALARM_EN adds bus.alarm, a sticky flag
// raised after FAIL_THRESH consecutive fails/timeouts.
module rng_test_sequencer
  import rng_seq_pkg::*;
#(
  parameter int SEQ_LEN     = DEF_SEQ_LEN,
  parameter int NUM_TESTS   = DEF_NUM_TESTS,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int FAIL_THRESH = DEF_FAIL_THRESH
) (
  input logic   clk,
  input logic   rst,
  rng_seq_if.slave bus
);

  localparam int CW = cnt_w(NUM_TESTS);
  localparam int TW = idx_w(TIMEOUT);
  localparam logic [CW-1:0] NT = CW'(NUM_TESTS);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] pass_cnt;
  logic [CW-1:0] test_cnt;
  logic          timeout_err;
  logic [TW-1:0] tmo_cnt;

  logic run_clr;
  logic verdict;
  logic tmo_hit;
  logic last_bit;
  logic feed_en;
  logic eps_bit;
  logic eps_vld;

  rng_bit_feeder #(
    .SEQ_LEN(SEQ_LEN)
  ) u_feeder (
    .clk        (clk),
    .rst        (rst),
    .clr        (run_clr),
    .en         (feed_en),
    .rng_bit    (bus.rng_bit),
    .rng_bit_vld(bus.rng_bit_vld),
    .eps_bit    (eps_bit),
    .eps_vld    (eps_vld),
    .last_bit   (last_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // A verdict in the final timeout cycle takes priority over the timeout.
  always_comb begin
    state_nxt = state;
    run_clr   = 1'b0;
    verdict   = 1'b0;
    tmo_hit   = 1'b0;
    feed_en   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          run_clr   = 1'b1;
          state_nxt = FEED;
        end
      end
      FEED: begin
        feed_en = 1'b1;
        if (last_bit)
          state_nxt = WAIT;
      end
      WAIT: begin
        verdict = bus.core_valid;
        tmo_hit = ~bus.core_valid & (tmo_cnt == TMO_LAST);
        if (verdict || tmo_hit)
          state_nxt = NEXT;
      end
      NEXT: begin
        state_nxt = (test_cnt == NT) ? DONE : FEED;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_cnt    <= '0;
      test_cnt    <= '0;
      timeout_err <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      if (state == WAIT && !verdict && !tmo_hit)
        tmo_cnt <= tmo_cnt + 1'b1;
      else
        tmo_cnt <= '0;

      if (run_clr)
        pass_cnt <= '0;
      else if (verdict && bus.core_is_random && pass_cnt < NT)
        pass_cnt <= pass_cnt + 1'b1;

      if (run_clr)
        test_cnt <= '0;
      else if ((verdict || tmo_hit) && test_cnt < NT)
        test_cnt <= test_cnt + 1'b1;

      if (run_clr)
        timeout_err <= 1'b0;
      else if (tmo_hit)
        timeout_err <= 1'b1;
    end
  end

`ifdef RNG_SEQ_FAIL_ALARM_EN
  localparam int SW = cnt_w(FAIL_THRESH);
  localparam logic [SW-1:0] FT = SW'(FAIL_THRESH);

  logic [SW-1:0] streak;
  logic          alarm;
  logic          fail_ev;
  logic          pass_ev;

  assign fail_ev = (verdict & ~bus.core_is_random) | tmo_hit;
  assign pass_ev = verdict & bus.core_is_random;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak <= '0;
      alarm  <= 1'b0;
    end else begin
      if (run_clr || pass_ev)
        streak <= '0;
      else if (fail_ev && streak < FT)
        streak <= streak + 1'b1;

      if (run_clr)
        alarm <= 1'b0;
      else if (fail_ev && streak >= FT - 1'b1)
        alarm <= 1'b1;
    end
  end

  assign bus.alarm = alarm;
`endif

  assign bus.eps_bit     = eps_bit;
  assign bus.eps_vld     = eps_vld;
  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.pass_cnt    = pass_cnt;
  assign bus.test_cnt    = test_cnt;
  assign bus.timeout_err = timeout_err;

endmodule

// File: tb/tb_rng_test_sequencer.sv
// tb_rng_test_sequencer: table-driven runs plus reset/start corner cases.
// SEQ_LEN=8, NUM_TESTS=4, TIMEOUT=16, FAIL_THRESH=3.
module tb_rng_test_sequencer;
  import rng_seq_pkg::*;

  localparam int SL = 8;
  localparam int NT = 4;
  localparam int TO = 16;
  localparam int FT = 3;
  localparam int CW = cnt_w(NT);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rng_seq_if #(.CW(CW)) bus ();

  rng_test_sequencer #(
    .SEQ_LEN    (SL),
    .NUM_TESTS  (NT),
    .TIMEOUT    (TO),
    .FAIL_THRESH(FT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // mode per test (2 bits): 0 verdict 5 cycles after last bit,
  // 1 core silent (timeout), 2 verdict coincident with expiry.
  typedef struct {
    logic [3:0] verd;
    logic [7:0] mode;
    int         stall;
    logic       abuse;
    int         exp_pass;
    int         exp_test;
    logic       exp_tmo;
    logic       exp_alarm;
  } vec_t;

  vec_t vecs[7];

  int n_chk  = 0;
  int n_fail = 0;
  int eps_n  = 0;
  int done_n = 0;
  bit got_q[$];
  bit exp_q[$];
  logic seen_tmo;
  int   run_pass;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.eps_vld) begin
        eps_n <= eps_n + 1;
        got_q.push_back(bus.eps_bit);
      end
      if (bus.done)
        done_n <= done_n + 1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic vld_pat(input int stall, input int k);
    case (stall)
      1:       return (k % 2) == 0;
      2:       return (k % 4) != 1;
      default: return 1'b1;
    endcase
  endfunction

  // Called right after the edge that put the DUT in FEED.
  task automatic feed(input int stall, input logic abuse);
    int sent = 0;
    int k = 0;
    logic v;
    while (sent < SL) begin
      v = vld_pat(stall, k);
      bus.rng_bit        = 1'($urandom_range(0, 1));
      bus.rng_bit_vld    = v;
      bus.core_valid     = (stall == 2) && !v;
      bus.core_is_random = 1'b1;
      bus.start          = abuse && (k == 3);
      if (v) begin
        exp_q.push_back(bus.rng_bit);
        sent++;
      end
      tick();
      k++;
    end
    bus.rng_bit_vld = 1'b0;
    bus.core_valid  = 1'b0;
    bus.start       = 1'b0;
  endtask

  // Called right after the edge that put the DUT in WAIT; ends in NEXT.
  task automatic respond(input logic verdict, input logic [1:0] mode);
    case (mode)
      2'd1: begin
        repeat (TO - 1) tick();
        check("tmo_not_early", bus.timeout_err, seen_tmo);
        tick();
        seen_tmo = 1'b1;
        check("tmo_set", bus.timeout_err, 1);
      end
      2'd2: begin
        repeat (TO - 1) tick();
        bus.core_valid     = 1'b1;
        bus.core_is_random = verdict;
        tick();
        bus.core_valid = 1'b0;
        check("tmo_coincide", bus.timeout_err, seen_tmo);
        if (verdict) run_pass++;
      end
      default: begin
        repeat (4) tick();
        bus.core_valid     = 1'b1;
        bus.core_is_random = verdict;
        tick();
        bus.core_valid = 1'b0;
        if (verdict) run_pass++;
      end
    endcase
    check("pass_step", bus.pass_cnt, run_pass);
  endtask

  task automatic run_vec(input vec_t v);
    int base_eps;
    int base_got;
    int base_done;
    int bad;
    exp_q.delete();
    base_eps  = eps_n;
    base_got  = got_q.size();
    base_done = done_n;
    seen_tmo  = 1'b0;
    run_pass  = 0;
    bus.start = 1'b1;
    check("busy_pre", bus.busy, 0);
    tick();
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
    check("cnt_cleared", bus.test_cnt, 0);
    for (int t = 0; t < NT; t++) begin
      feed(v.stall, v.abuse && t == 0);
      respond(v.verd[t], v.mode[2*t +: 2]);
      check("test_step", bus.test_cnt, t + 1);
      tick();
    end
    check("done_hi", bus.done, 1);
    check("busy_in_done", bus.busy, 1);
    tick();
    check("done_lo", bus.done, 0);
    check("busy_idle", bus.busy, 0);
    repeat (3) tick();
    check("pass_cnt", bus.pass_cnt, v.exp_pass);
    check("test_cnt", bus.test_cnt, v.exp_test);
    check("timeout_err", bus.timeout_err, v.exp_tmo);
    check("eps_count", eps_n - base_eps, SL * NT);
    check("done_count", done_n - base_done, 1);
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (base_got + i >= got_q.size() || got_q[base_got + i] != exp_q[i])
        bad++;
    check("eps_bits", bad, 0);
`ifdef RNG_SEQ_FAIL_ALARM_EN
    check("alarm", bus.alarm, v.exp_alarm);
`endif
  endtask

  initial begin
    vecs[0] = '{4'b1111, 8'h00, 0, 1'b1, 4, 4, 1'b0, 1'b0};
    vecs[1] = '{4'b0101, 8'h00, 1, 1'b0, 2, 4, 1'b0, 1'b0};
    vecs[2] = '{4'b1101, 8'h04, 2, 1'b0, 3, 4, 1'b1, 1'b0};
    vecs[3] = '{4'b1010, 8'hAA, 0, 1'b0, 2, 4, 1'b0, 1'b0};
    vecs[4] = '{4'b0000, 8'h00, 1, 1'b0, 0, 4, 1'b0, 1'b1};
    vecs[5] = '{4'b0100, 8'h01, 0, 1'b0, 1, 4, 1'b1, 1'b0};
    vecs[6] = '{4'b1000, 8'h10, 2, 1'b0, 1, 4, 1'b1, 1'b1};

    bus.start          = 1'b0;
    bus.rng_bit        = 1'b0;
    bus.rng_bit_vld    = 1'b0;
    bus.core_valid     = 1'b0;
    bus.core_is_random = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_pass", bus.pass_cnt, 0);
    check("rst_test", bus.test_cnt, 0);
    check("rst_tmo", bus.timeout_err, 0);
    check("rst_eps_vld", bus.eps_vld, 0);
`ifdef RNG_SEQ_FAIL_ALARM_EN
    check("rst_alarm", bus.alarm, 0);
`endif

    // Verdict outside WAIT must be ignored.
    bus.core_valid     = 1'b1;
    bus.core_is_random = 1'b1;
    repeat (2) tick();
    bus.core_valid = 1'b0;
    check("idle_verdict_ignored", bus.pass_cnt, 0);

    for (int i = 0; i < 7; i++)
      run_vec(vecs[i]);

    // Reset in the middle of WAIT of the second test.
    begin
      int base_done;
      base_done = done_n;
      seen_tmo  = 1'b0;
      run_pass  = 0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      feed(0, 1'b0);
      respond(1'b1, 2'd0);
      tick();
      feed(0, 1'b0);
      repeat (2) tick();
      check("pre_rst_busy", bus.busy, 1);
      rst = 1'b1;
      #2;
      check("async_busy", bus.busy, 0);
      check("async_pass", bus.pass_cnt, 0);
      check("async_test", bus.test_cnt, 0);
      check("async_eps_vld", bus.eps_vld, 0);
      check("async_eps_bit", bus.eps_bit, 0);
      check("async_done", bus.done, 0);
      tick();
      rst = 1'b0;
      repeat (2) tick();
      check("no_done_on_rst", done_n - base_done, 0);
    end

    run_vec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rng_test_sequencer.md
Name: rng_test_sequencer

Overview:
- Run controller for the approximate-entropy randomness test core.
- Gates raw RNG bits into the core as fixed-length epsilon sequences, then waits for each verdict.
- Repeats for NUM_TESTS sequences and reports a pass count plus a timeout/error summary.
- Sits between the entropy source and the test core, under the top-level I/O wrapper.

Parameters:
- SEQ_LEN, 128: epsilon bits per test sequence (≥2).
- NUM_TESTS, 16: sequences per run (≥1).
- TIMEOUT, 1024: max cycles to wait for the core verdict after the last bit (≥1).
- FAIL_THRESH, 3: consecutive fails that raise alarm (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle run request; ignored unless IDLE.
- rng_bit  in  1  raw entropy bit.
- rng_bit_vld  in  1  rng_bit qualifier.
- eps_bit  out  1  epsilon bit to the test core.
- eps_vld  out  1  eps_bit qualifier to the core.
- core_valid  in  1  core verdict strobe, one cycle.
- core_is_random  in  1  core verdict, sampled when core_valid=1.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse at end of run.
- pass_cnt  out  CW  passing sequences in the last/current run; CW=$clog2(NUM_TESTS+1).
- test_cnt  out  CW  sequences completed (pass, fail or timeout).
- timeout_err  out  1  sticky per run; set if any verdict timed out.

Behaviour:
- Reset (asynchronous): state=IDLE; all outputs 0; all counters 0.
- States: IDLE, FEED, WAIT, NEXT, DONE.
- IDLE:
  - On start=1: clear pass_cnt, test_cnt, timeout_err and bit counter; go to FEED next cycle.
  - busy rises the cycle after start.
- FEED:
  - eps_bit<=rng_bit and eps_vld<=rng_bit_vld, registered (1-cycle latency).
  - Bit counter increments only when rng_bit_vld=1.
  - When the count reaches SEQ_LEN-1 with rng_bit_vld=1: last bit is forwarded, counter clears, go to WAIT.
  - No bits are dropped or duplicated; stalls on rng_bit_vld=0 for any length.
- WAIT:
  - eps_vld=0. Timeout counter runs from 0.
  - core_valid=1: if core_is_random, pass_cnt++; test_cnt++; go to NEXT.
  - Timeout counter reaches TIMEOUT-1 with no core_valid: timeout_err<=1; test_cnt++ (counted as fail); go to NEXT.
  - If core_valid and the timeout expire in the same cycle, the verdict wins (no timeout_err).
  - core_valid seen in any state other than WAIT is ignored.
- NEXT (1 cycle): go to DONE if test_cnt==NUM_TESTS, else to FEED.
- DONE (1 cycle): done=1, busy=0 next, go to IDLE.
  - pass_cnt, test_cnt and timeout_err hold until the next start.
- Counters never wrap: pass_cnt ≤ test_cnt ≤ NUM_TESTS.
- start while busy is ignored (no restart).
- rst mid-run aborts immediately; everything returns to reset values and no done pulse is issued.

Optional Feature:
- Macro RNG_SEQ_FAIL_ALARM_EN.
- Defined:
  - Extra output port alarm (1 bit, sticky until start or rst).
  - Consecutive-fail counter increments on fail or timeout and clears on pass.
  - alarm<=1 when the counter reaches FAIL_THRESH.
  - A run with alarm set still completes normally.
- Undefined: no alarm port and no fail-streak logic; all other behaviour identical.

Decomposition:
- Package rng_seq_pkg holds:
  - state enum (IDLE, FEED, WAIT, NEXT, DONE);
  - localparam CW derivation helper;
  - default constants for SEQ_LEN, NUM_TESTS, TIMEOUT, FAIL_THRESH.
- One sub-module, rng_bit_feeder: gated register stage plus SEQ_LEN bit counter; raises last_bit.
- FSM, verdict counters and timeout counter stay in the top.

Test Plan:
- Basic run: SEQ_LEN=8, NUM_TESTS=2, rng_bit_vld always 1, core_valid+is_random=1 five cycles after each last bit -> 16 eps_vld pulses total, pass_cnt=2, test_cnt=2, done pulses once, timeout_err=0.
- Stalled source: rng_bit_vld toggling 1010… with pattern 1,0,1,1,… -> eps_bit sequence equals the valid-qualified rng_bit sequence exactly; 8 eps_vld per test.
- Mixed verdicts: NUM_TESTS=4, verdicts 1,0,1,0 -> pass_cnt=2, test_cnt=4.
- Timeout: TIMEOUT=16, core silent for test 1 only -> timeout_err=1 after 16 WAIT cycles, test_cnt=2, pass_cnt=1; core_valid coincident with expiry in a second run -> timeout_err=0.
- Reset/start abuse: start pulsed during FEED is ignored; rst asserted mid-WAIT -> all outputs 0 same cycle (async), no done; a new start then runs cleanly.
- Alarm (macro defined, FAIL_THRESH=3, NUM_TESTS=5): verdicts 0,0,1,0,0 -> alarm=0; verdicts 0,0,0,1,1 -> alarm=1 after test 3 and held through done.
